// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB slave register file
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } apb_state_t;

  localparam int WAIT_W = 4;

  localparam logic OKAY   = 1'b0;
  localparam logic SLVERR = 1'b1;

  // Number of byte-lane address bits below the word index.
  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// rtl/apb_wait_ctr.sv - loadable down-counter with zero/last flags for APB wait states
module apb_wait_ctr
  import apb_pkg::*;
#(
  parameter int W = WAIT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         last
);

  // Saturates at zero so a full-scale load never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
  assign last = (count == W'(1));

endmodule

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB register file slave with wait states and PSLVERR; APB_SLV_PSTRB_EN adds byte strobes
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int           ADDR_W      = 32,
  parameter int           DATA_W      = 32,
  parameter int           DEPTH       = 16,
  parameter int           WAIT_CYCLES = 0,
  parameter logic [255:0] RO_MASK     = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       paddr,
  input  logic [DATA_W-1:0]       pwdata,
  input  logic                    pwrite,
  input  logic                    psel,
  input  logic                    penable,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_W/8-1:0]     pstrb,
`endif
  output logic [DATA_W-1:0]       prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic [DEPTH*DATA_W-1:0] reg_q
);

  localparam int LB    = lane_bits(DATA_W);
  localparam int IW    = ADDR_W - LB;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB    = DATA_W / 8;

  apb_state_t        state;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [IW-1:0]     full_idx;
  logic [IDX_W-1:0]  idx;
  logic [NB-1:0]     be;
  logic [WAIT_W-1:0] cnt;
  logic              cnt_zero, cnt_last;
  logic              legal, ro_hit, setup, fire, wr_fire, err;

  assign full_idx = paddr[ADDR_W-1:LB];
  assign idx      = full_idx[IDX_W-1:0];
  assign legal    = (paddr[LB-1:0] == '0) && (full_idx < IW'(DEPTH));
  assign ro_hit   = RO_MASK[idx];
  assign setup    = psel && !penable;
  assign err      = !legal || (pwrite && ro_hit);

`ifdef APB_SLV_PSTRB_EN
  assign be = pstrb;
`else
  assign be = '1;
`endif

  // fire marks the edge that raises pready: straight from setup when there is no stall.
  assign fire = ((state != ACCESS) && setup && (WAIT_CYCLES == 0)) ||
                ((state == ACCESS) && psel && penable && !pready && (cnt_zero || cnt_last));
  assign wr_fire = (state == ACCESS) && psel && penable && pready && pwrite && legal && !ro_hit;

  apb_wait_ctr #(.W(WAIT_W)) u_wait_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     ((state != ACCESS) && setup),
    .load_val (WAIT_W'(WAIT_CYCLES)),
    .dec      ((state == ACCESS) && psel && !pready),
    .count    (cnt),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pready  <= 1'b0;
      pslverr <= OKAY;
      prdata  <= '0;
    end else begin
      case (state)
        IDLE, DONE: state <= setup ? ACCESS : IDLE;
        ACCESS: begin
          if (!psel)       state <= IDLE;
          else if (pready) state <= DONE;
        end
        default: state <= IDLE;
      endcase
      if (fire) begin
        pready  <= 1'b1;
        pslverr <= err ? SLVERR : OKAY;
        if (!pwrite) prdata <= legal ? regs[idx] : '0;
      end else begin
        pready  <= 1'b0;
        pslverr <= OKAY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_fire) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) regs[idx][b*8 +: 8] <= pwdata[b*8 +: 8];
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - directed self-checking bench for apb_slave_regfile
module tb_apb_slave_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] paddr, pwdata;
  logic        pwrite, penable;
  logic [2:0]  psel_v;
`ifdef APB_SLV_PSTRB_EN
  logic [3:0]  pstrb;
`endif
  logic [31:0]  prdata  [3];
  logic         pready  [3];
  logic         pslverr [3];
  logic [511:0] reg_q   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_slave_regfile #(.WAIT_CYCLES(0), .RO_MASK(256'h1)) dut0 (
    .clk(clk), .rst(rst), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel_v[0]), .penable(penable),
`ifdef APB_SLV_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]), .reg_q(reg_q[0])
  );

  apb_slave_regfile #(.WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel_v[1]), .penable(penable),
`ifdef APB_SLV_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]), .reg_q(reg_q[1])
  );

  apb_slave_regfile #(.WAIT_CYCLES(15)) dut2 (
    .clk(clk), .rst(rst), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel_v[2]), .penable(penable),
`ifdef APB_SLV_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]), .reg_q(reg_q[2])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_setup(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    psel_v    = '0;
    psel_v[d] = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = addr;
    pwdata    = wd;
  endtask

  // Ends on the negedge of the cycle after pready, with the bus idled.
  task automatic do_access(input int d, output logic [31:0] rd, output logic err, output int waits);
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    while (!pready[d] && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    rd  = prdata[d];
    err = pslverr[d];
    @(negedge clk);
    psel_v  = '0;
    penable = 1'b0;
  endtask

  task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int waits);
    @(negedge clk);
    do_setup(d, wr, addr, wd);
    do_access(d, rd, err, waits);
  endtask

  initial begin
    logic [31:0]  rd;
    logic         err;
    int           w;
    int           hits;
    logic [511:0] exp_q;

    rst = 1'b1; psel_v = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
`ifdef APB_SLV_PSTRB_EN
    pstrb = 4'hF;
`endif
    repeat (3) @(negedge clk);
    check("rst_pready",  pready[0],  0);
    check("rst_pslverr", pslverr[0], 0);
    check("rst_prdata",  prdata[0],  0);
    check("rst_regs",    |reg_q[0],  0);
    rst = 1'b0;

    xfer(0, 1'b0, 32'h0C, 0, rd, err, w);
    check("rd3_wait0", w, 0);
    check("rd3_data",  rd, 0);
    check("rd3_err",   err, 0);
    check("rd3_pready_one_cycle", pready[0], 0);

    xfer(1, 1'b1, 32'h08, 32'hDEADBEEF, rd, err, w);
    check("w3_wr_err",  err, 0);
    check("w3_wr_wait", w, 3);
    xfer(1, 1'b0, 32'h08, 0, rd, err, w);
    check("w3_rd_wait", w, 3);
    check("w3_rd_data", rd, 32'hDEADBEEF);
    check("w3_rd_err",  err, 0);
    check("w3_reg_q2",  reg_q[1][95:64], 32'hDEADBEEF);

    xfer(0, 1'b1, 32'h0C, 32'hA5A50001, rd, err, w);
    check("wr_idx3_err", err, 0);
    xfer(0, 1'b0, 32'h0C, 0, rd, err, w);
    check("rd_idx3_data", rd, 32'hA5A50001);
    xfer(0, 1'b0, 32'h40, 0, rd, err, w);
    check("rd_oob_err",  err, 1);
    check("rd_oob_data", rd, 0);
    xfer(0, 1'b1, 32'h40, 32'hFFFFFFFF, rd, err, w);
    check("wr_oob_err", err, 1);
    xfer(0, 1'b1, 32'h02, 32'hFFFFFFFF, rd, err, w);
    check("wr_mis_err", err, 1);
    xfer(0, 1'b0, 32'h0C, 0, rd, err, w);
    xfer(0, 1'b0, 32'h02, 0, rd, err, w);
    check("rd_mis_err",  err, 1);
    check("rd_mis_data", rd, 0);
    exp_q = '0;
    exp_q[127:96] = 32'hA5A50001;
    check("illegal_no_change", reg_q[0] == exp_q, 1);

    xfer(0, 1'b1, 32'h00, 32'h1234, rd, err, w);
    check("ro_err",  err, 1);
    check("ro_reg0", reg_q[0][31:0], 0);

    xfer(2, 1'b0, 32'h04, 0, rd, err, w);
    check("w15_wait", w, 15);
    check("w15_err",  err, 0);

`ifdef APB_SLV_PSTRB_EN
    pstrb = 4'hF;
    xfer(0, 1'b1, 32'h04, 32'hFFFFFFFF, rd, err, w);
    pstrb = 4'b0100;
    @(negedge clk);
    do_setup(0, 1'b1, 32'h04, 32'h00AB0000);
    do_access(0, rd, err, w);
    check("strb_wr_err", err, 0);
    do_setup(0, 1'b0, 32'h04, 0);
    do_access(0, rd, err, w);
    check("b2b_rd_wait", w, 0);
    check("b2b_rd_data", rd, 32'hFFABFFFF);
    pstrb = 4'b0000;
    xfer(0, 1'b1, 32'h04, 32'h12345678, rd, err, w);
    check("strb0_err", err, 0);
    check("strb0_reg", reg_q[0][63:32], 32'hFFABFFFF);
    pstrb = 4'hF;
`else
    @(negedge clk);
    do_setup(0, 1'b1, 32'h04, 32'h00AB0000);
    do_access(0, rd, err, w);
    check("full_wr_err", err, 0);
    do_setup(0, 1'b0, 32'h04, 0);
    do_access(0, rd, err, w);
    check("b2b_rd_wait", w, 0);
    check("b2b_rd_data", rd, 32'h00AB0000);
`endif

    @(negedge clk);
    do_setup(1, 1'b1, 32'h0C, 32'h55);
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel_v  = '0;
    penable = 1'b0;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pready[1]) hits++;
    end
    check("abort_pready", hits, 0);
    check("abort_no_write", reg_q[1][127:96], 0);

    @(negedge clk);
    do_setup(1, 1'b1, 32'h08, 32'h12345678);
    @(negedge clk);
    penable = 1'b1;
    w = 0;
    while (!pready[1] && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("rst_mid_pready_before", pready[1], 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_pready", pready[1], 0);
    check("rst_async_prdata", prdata[1], 0);
    check("rst_async_regs",   |reg_q[1], 0);
    @(negedge clk);
    psel_v  = '0;
    penable = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_write_lost", |reg_q[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
